multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//   Moore FSM that sequences the shared MIPS datapath (PC, unified memory, IR, register file, ALU) over multiple cycles per instruction.
//   Decodes Op/Funct from the IR and drives every datapath enable/select each cycle.
//   Waits on a memory-ready handshake in memory states.
//   Sits beside the datapath top; replaces the single-cycle combinational control unit.
// PARAMETERS
//   STATE_W     4  width of state register (12 states used)
//   ALUCTRL_W   3  width of ALUControl bus
// PORTS
//   clk         in   1  rising-edge clock, sole clock
//   reset       in   1  synchronous, active-high reset
//   Op          in   6  IR[31:26]
//   Funct       in   6  IR[5:0]
//   Zero        in   1  ALU zero flag
//   mem_ready   in   1  memory completes current access this cycle
//   IorD        out  1  0: mem addr=PC, 1: mem addr=ALUOut
//   MemWrite    out  1  memory write strobe
//   IRWrite     out  1  load IR from memory read data
//   RegWrite    out  1  register-file write enable (WE3)
//   RegDst      out  1  0: A3=rt, 1: A3=rd
//   MemtoReg    out  1  0: WD3=ALUOut, 1: WD3=Data reg
//   ALUSrcA     out  1  0: PC, 1: register A
//   ALUSrcB     out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//   ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//   PCSrc       out  2  00 ALUResult, 01 ALUOut, 10 jump target
//   PCEn        out  1  PC load = PCWrite | (Branch & branch_taken)
//   illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
// BEHAVIOUR
//   States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
//   reset=1 at an edge: state<=FETCH. While reset is high, all outputs are forced 0 (ALUControl=010, selects=0).
//   Reset mid-instruction aborts it; no partial write occurs after the reset edge.
//   FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00. Hold until mem_ready.
//     IRWrite and PCEn assert only in the mem_ready=1 cycle; then go to DECODE.
//   DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target precompute). Next state by Op:
//     lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH;
//     addi 001000 -> ADDIEX; j 000010 -> JUMP.
//     Other Op: illegal_op=1 for this cycle, then FETCH.
//   MEMADR: ALUSrcA=1, ALUSrcB=10, add. lw -> MEMRD, sw -> MEMWR.
//   MEMRD: IorD=1. Hold until mem_ready, then MEMWB.
//   MEMWB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
//   MEMWR: IorD=1, MemWrite=1 held every cycle until mem_ready=1 -> FETCH.
//   EXECUTE: ALUSrcA=1, ALUSrcB=00. Funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
//     Other Funct: illegal_op=1, no ALUWB, next FETCH.
//   ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
//   BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1. PCEn=Zero -> FETCH.
//   ADDIEX: ALUSrcA=1, ALUSrcB=10, add. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
//   JUMP: PCSrc=10, PCEn=1 -> FETCH.
//   Cycles with mem_ready always 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
//     Each memory wait cycle adds 1.
//   All outputs are pure functions of state (plus mem_ready, Zero, Op, Funct for the strobes noted). No glitch storage.
// CONFIGURATION
//   MCC_BNE_EN defined: Op 000101 (bne) is decoded to BRANCH; PCEn = ~Zero for bne, Zero for beq.
//     Op is sampled into a 1-bit flag in DECODE.
//   MCC_BNE_EN undefined: 000101 is illegal (illegal_op pulse, back to FETCH).
// STRUCTURE
//   Package mips_ctrl_pkg: opcode/funct localparams, state encoding, ALUControl codes, ALUSrcB/PCSrc codes.
//   Sub-module alu_decoder: combinational ALUOp[1:0] + Funct -> ALUControl, with funct_illegal flag.
//   FSM and output decode stay in this module.
// TESTING
//   reset=1 for 2 cycles, mem_ready=1 -> all outputs 0 during reset.
//     First cycle after release: FETCH with IRWrite=1, PCEn=1.
//   lw (Op=100011), mem_ready=1 -> states F,D,MA,MR,MWB.
//     RegWrite=1 only in cycle 5, with MemtoReg=1, RegDst=0.
//   sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH. RegWrite never 1.
//   beq with Zero=1 -> PCEn=1, PCSrc=01 in cycle 3. Zero=0 -> PCEn=0. Instruction takes 3 cycles.
//   R-type Funct=101010 -> ALUControl=111 in EXECUTE. Funct=000111 -> illegal_op pulse, no RegWrite, next FETCH.
//   reset asserted during MEMWR wait -> next cycle FETCH, MemWrite=0.
//   With MCC_BNE_EN, Op=000101, Zero=0 -> PCEn=1.
//     Without MCC_BNE_EN, same stimulus -> illegal_op pulse in DECODE.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, states, select codes.
// MCC_BNE_EN (optional define) adds bne decoding to the supported-opcode check.
package mips_ctrl_pkg;

    localparam int STATE_W   = 4;
    localparam int ALUCTRL_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MCC_BNE_EN
        ok = ok || (op == OP_BNE);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and flags in, enables/selects out.
interface multicycle_controller_if;
    import mips_ctrl_pkg::*;

    logic [5:0]           Op;
    logic [5:0]           Funct;
    logic                 Zero;
    logic                 mem_ready;
    logic                 IorD;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 RegWrite;
    logic                 RegDst;
    logic                 MemtoReg;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [1:0]           PCSrc;
    logic                 PCEn;
    logic                 illegal_op;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALUOp + Funct -> ALUControl; flags functs the ALU cannot execute.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t               alu_op,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared MIPS datapath; outputs decoded from state only.
// Optional define MCC_BNE_EN adds bne (branch on ~Zero) to the BRANCH state.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_controller_if.master bus
);

    state_t               state_q, state_d;
    aluop_t               alu_op;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 funct_illegal;
    logic                 taken;
    ctrl_t                ctrl;

    alu_decoder u_alu_dec (
        .alu_op        (alu_op),
        .funct         (bus.Funct),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

`ifdef MCC_BNE_EN
    // The branch sense is latched at decode so BRANCH does not depend on Op.
    logic is_bne_q;
    always_ff @(posedge clk) begin
        if (reset)                      is_bne_q <= 1'b0;
        else if (state_q == S_DECODE)   is_bne_q <= (bus.Op == OP_BNE);
    end
    assign taken = is_bne_q ? ~bus.Zero : bus.Zero;
`else
    assign taken = bus.Zero;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MCC_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.Op == OP_LW)      state_d = S_MEMRD;
                else if (bus.Op == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXECUTE: state_d = funct_illegal ? S_FETCH : S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Kept apart from the output decode so the decoder's illegal flag feeds back without a comb loop.
    always_comb begin
        alu_op = ALUOP_ADD;
        if (!reset) begin
            case (state_q)
                S_EXECUTE: alu_op = ALUOP_FUNCT;
                S_BRANCH:  alu_op = ALUOP_SUB;
                default:   alu_op = ALUOP_ADD;
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.ir_write  = bus.mem_ready;
                    ctrl.pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.illegal   = !op_supported(bus.Op);
                end
                S_MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                S_MEMRD: ctrl.iord = 1'b1;
                S_MEMWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.memto_reg = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.iord      = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    ctrl.illegal   = funct_illegal;
                end
                S_ALUWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    ctrl.pc_src    = PC_ALUOUT;
                    ctrl.branch    = 1'b1;
                end
                S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                S_ADDIWB: ctrl.reg_write = 1'b1;
                S_JUMP: begin
                    ctrl.pc_src   = PC_JUMP;
                    ctrl.pc_write = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign bus.IorD       = ctrl.iord;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.IRWrite    = ctrl.ir_write;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.RegDst     = ctrl.reg_dst;
    assign bus.MemtoReg   = ctrl.memto_reg;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.PCSrc      = ctrl.pc_src;
    assign bus.PCEn       = ctrl.pc_write | (ctrl.branch & taken);
    assign bus.illegal_op = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller; honours MCC_BNE_EN if defined.
module tb_multicycle_controller;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IorD,MemWrite,IRWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUControl,PCSrc,PCEn,illegal_op}
    function automatic logic [15:0] mk(input logic iord, input logic mw, input logic irw,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic sa, input logic [1:0] sb, input logic [2:0] ac,
                                       input logic [1:0] ps, input logic pce, input logic ill);
        return {iord, mw, irw, rw, rd, m2r, sa, sb, ac, ps, pce, ill};
    endfunction

    function automatic logic [15:0] outs();
        return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.PCSrc, bus.PCEn, bus.illegal_op};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    endtask

    // Check the current cycle's outputs, then advance one clock.
    task automatic cyc(input string tag, input logic [15:0] exp);
        #1 check(tag, outs(), exp);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] V_RST, V_FETCH, V_FETCH_W, V_DEC, V_DEC_ILL, V_MEMADR, V_MEMRD, V_MEMWB,
                 V_MEMWR, V_EXE_SLT, V_EXE_ILL, V_ALUWB, V_BR_T, V_BR_NT, V_ADDIEX, V_ADDIWB, V_JUMP;

    initial begin
        n_chk = 0;
        n_pass = 0;
        V_RST     = mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        V_FETCH   = mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0);
        V_FETCH_W = mk(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0);
        V_DEC     = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
        V_DEC_ILL = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1);
        V_MEMADR  = mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
        V_MEMRD   = mk(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        V_MEMWB   = mk(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0);
        V_MEMWR   = mk(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        V_EXE_SLT = mk(0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0);
        V_EXE_ILL = mk(0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,1);
        V_ALUWB   = mk(0,0,0,1,1,0,0,2'b00,3'b010,2'b00,0,0);
        V_BR_T    = mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0);
        V_BR_NT   = mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,0);
        V_ADDIEX  = mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
        V_ADDIWB  = mk(0,0,0,1,0,0,0,2'b00,3'b010,2'b00,0,0);
        V_JUMP    = mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0);

        reset = 1'b1;
        bus.Op = 6'b000000;
        bus.Funct = 6'b000000;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b1;

        cyc("rst0", V_RST);
        cyc("rst1", V_RST);
        reset = 1'b0;

        // lw, no waits: 5 cycles
        bus.Op = 6'b100011;
        cyc("lw_fetch", V_FETCH);
        cyc("lw_dec", V_DEC);
        cyc("lw_memadr", V_MEMADR);
        cyc("lw_memrd", V_MEMRD);
        cyc("lw_memwb", V_MEMWB);

        // sw with 3 wait cycles in MEMWR
        bus.Op = 6'b101011;
        cyc("sw_fetch", V_FETCH);
        cyc("sw_dec", V_DEC);
        cyc("sw_memadr", V_MEMADR);
        bus.mem_ready = 1'b0;
        cyc("sw_wait0", V_MEMWR);
        cyc("sw_wait1", V_MEMWR);
        cyc("sw_wait2", V_MEMWR);
        bus.mem_ready = 1'b1;
        cyc("sw_memwr", V_MEMWR);

        // beq taken
        bus.Op = 6'b000100;
        bus.Zero = 1'b1;
        cyc("beq_t_fetch", V_FETCH);
        cyc("beq_t_dec", V_DEC);
        cyc("beq_t_br", V_BR_T);

        // beq not taken
        bus.Zero = 1'b0;
        cyc("beq_nt_fetch", V_FETCH);
        cyc("beq_nt_dec", V_DEC);
        cyc("beq_nt_br", V_BR_NT);

        // R-type slt
        bus.Op = 6'b000000;
        bus.Funct = 6'b101010;
        cyc("slt_fetch", V_FETCH);
        cyc("slt_dec", V_DEC);
        cyc("slt_exe", V_EXE_SLT);
        cyc("slt_aluwb", V_ALUWB);

        // R-type illegal funct: no ALUWB
        bus.Funct = 6'b000111;
        cyc("rill_fetch", V_FETCH);
        cyc("rill_dec", V_DEC);
        cyc("rill_exe", V_EXE_ILL);

        // addi with one fetch wait, then lw with one MEMRD wait
        bus.Op = 6'b001000;
        bus.mem_ready = 1'b0;
        cyc("addi_fwait", V_FETCH_W);
        bus.mem_ready = 1'b1;
        cyc("addi_fetch", V_FETCH);
        cyc("addi_dec", V_DEC);
        cyc("addi_ex", V_ADDIEX);
        cyc("addi_wb", V_ADDIWB);

        bus.Op = 6'b100011;
        cyc("lw2_fetch", V_FETCH);
        cyc("lw2_dec", V_DEC);
        cyc("lw2_memadr", V_MEMADR);
        bus.mem_ready = 1'b0;
        cyc("lw2_rdwait", V_MEMRD);
        bus.mem_ready = 1'b1;
        cyc("lw2_memrd", V_MEMRD);
        cyc("lw2_memwb", V_MEMWB);

        // jump
        bus.Op = 6'b000010;
        cyc("j_fetch", V_FETCH);
        cyc("j_dec", V_DEC);
        cyc("j_jump", V_JUMP);

        // unsupported opcode
        bus.Op = 6'b111111;
        cyc("ill_fetch", V_FETCH);
        cyc("ill_dec", V_DEC_ILL);

        // reset in the middle of a MEMWR wait aborts the store
        bus.Op = 6'b101011;
        cyc("swr_fetch", V_FETCH);
        cyc("swr_dec", V_DEC);
        cyc("swr_memadr", V_MEMADR);
        bus.mem_ready = 1'b0;
        cyc("swr_wait", V_MEMWR);
        reset = 1'b1;
        cyc("swr_reset", V_RST);
        reset = 1'b0;
        cyc("swr_after", V_FETCH_W);
        bus.mem_ready = 1'b1;

        // bne
        bus.Op = 6'b000101;
        bus.Zero = 1'b0;
        cyc("bne_fetch", V_FETCH);
`ifdef MCC_BNE_EN
        cyc("bne_dec", V_DEC);
        cyc("bne_br_t", V_BR_T);
        bus.Zero = 1'b1;
        cyc("bne2_fetch", V_FETCH);
        cyc("bne2_dec", V_DEC);
        cyc("bne2_br_nt", V_BR_NT);
        bus.Op = 6'b000100;
        cyc("beq3_fetch", V_FETCH);
        cyc("beq3_dec", V_DEC);
        cyc("beq3_br_t", V_BR_T);
`else
        cyc("bne_dec_ill", V_DEC_ILL);
`endif
        cyc("final_fetch", V_FETCH);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
